// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared widths and entry layout for the banked reorder buffer.
package rob_alloc_ctrl_pkg;

  localparam int DISPATCH_WIDTH       = 2;
  localparam int DISPATCH_ADDR_WIDTH  = 1;
  localparam int ROB_ADDR_WIDTH       = 3;
  localparam int ROB_ROWS             = 1 << ROB_ADDR_WIDTH;
  localparam int ARCH_REGS_ADDR_WIDTH = 5;
  localparam int PHYS_REGS_ADDR_WIDTH = 6;

  typedef struct packed {
    logic                            valid;
    logic                            done;
    logic [ARCH_REGS_ADDR_WIDTH-1:0] arch_rd;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the ROB; flush outranks alloc and retire.
module rob_ptr_ctrl
  import rob_alloc_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc,
  input  logic                      retire,
  input  logic                      flush,
  output logic [ROB_ADDR_WIDTH-1:0] head,
  output logic [ROB_ADDR_WIDTH-1:0] tail,
  output logic [ROB_ADDR_WIDTH:0]   count,
  output logic                      full
);

  localparam logic [ROB_ADDR_WIDTH-1:0] PTR_ONE   = ROB_ADDR_WIDTH'(1);
  localparam logic [ROB_ADDR_WIDTH:0]   CNT_ONE   = (ROB_ADDR_WIDTH + 1)'(1);
  localparam logic [ROB_ADDR_WIDTH:0]   CNT_LIMIT = (ROB_ADDR_WIDTH + 1)'(ROB_ROWS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc)
        tail <= tail + PTR_ONE;
      if (retire)
        head <= head + PTR_ONE;
      // simultaneous alloc and retire leave occupancy unchanged
      if (alloc && !retire)
        count <= count + CNT_ONE;
      else if (retire && !alloc)
        count <= count - CNT_ONE;
    end
  end

  assign full = (count == CNT_LIMIT);

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation/retirement: one row per dispatch group, lane i in bank i, in-order row retire.
module rob_alloc_ctrl
  import rob_alloc_ctrl_pkg::*;
#(
  parameter int WB_WIDTH = 2
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic [DISPATCH_WIDTH-1:0]                             dispatch_en,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0]   dispatch_arch_rd,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]   dispatch_phys_rd,
  output logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]         dispatch_rob_addr,
  output logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]    dispatch_bank_addr,
  output logic                                                  dispatch_full,
  input  logic [WB_WIDTH-1:0]                                   cmpl_en,
  input  logic [WB_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]               cmpl_rob_addr,
  input  logic [WB_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]          cmpl_bank_addr,
  input  logic                                                  flush,
  output logic [DISPATCH_WIDTH-1:0]                             commit_en,
  output logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0]   commit_arch_rd,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]   commit_phys_rd,
  output logic [ROB_ADDR_WIDTH-1:0]                             commit_rob_addr
);

  rob_entry_t [DISPATCH_WIDTH-1:0] rows [ROB_ROWS];

  logic [ROB_ADDR_WIDTH-1:0] head;
  logic [ROB_ADDR_WIDTH-1:0] tail;
  logic [ROB_ADDR_WIDTH:0]   count;
  logic                      full;
  logic                      alloc;
  logic                      retire;
  logic                      retirable;
  logic                      row_done;

  assign alloc  = (|dispatch_en) && !full && !flush;
  assign retire = retirable && !flush;

  rob_ptr_ctrl u_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .alloc  (alloc),
    .retire (retire),
    .flush  (flush),
    .head   (head),
    .tail   (tail),
    .count  (count),
    .full   (full)
  );

  assign dispatch_full = full;

  always_comb begin
    dispatch_rob_addr  = '0;
    dispatch_bank_addr = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      dispatch_rob_addr[i]  = tail;
      dispatch_bank_addr[i] = DISPATCH_ADDR_WIDTH'(i);
    end
  end

  // retire check and commit outputs look only at registered state
  always_comb begin
    row_done       = 1'b1;
    commit_en      = '0;
    commit_arch_rd = '0;
    commit_phys_rd = '0;
    for (int b = 0; b < DISPATCH_WIDTH; b++) begin
      if (rows[head][b].valid && !rows[head][b].done)
        row_done = 1'b0;
    end
    retirable = (count != '0) && row_done;
    for (int b = 0; b < DISPATCH_WIDTH; b++) begin
      commit_en[b]      = retirable && rows[head][b].valid;
      commit_arch_rd[b] = rows[head][b].arch_rd;
      commit_phys_rd[b] = rows[head][b].phys_rd;
    end
    commit_rob_addr = head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROB_ROWS; r++)
        for (int b = 0; b < DISPATCH_WIDTH; b++)
          rows[r][b] <= '0;
    end else if (flush) begin
      for (int r = 0; r < ROB_ROWS; r++)
        for (int b = 0; b < DISPATCH_WIDTH; b++) begin
          rows[r][b].valid <= 1'b0;
          rows[r][b].done  <= 1'b0;
        end
    end else begin
      for (int k = 0; k < WB_WIDTH; k++) begin
        if (cmpl_en[k] && rows[cmpl_rob_addr[k]][cmpl_bank_addr[k]].valid)
          rows[cmpl_rob_addr[k]][cmpl_bank_addr[k]].done <= 1'b1;
      end
      if (retire) begin
        for (int b = 0; b < DISPATCH_WIDTH; b++) begin
          rows[head][b].valid <= 1'b0;
          rows[head][b].done  <= 1'b0;
        end
      end
      // tail equals head only when empty (no retire) or full (no alloc)
      if (alloc) begin
        for (int b = 0; b < DISPATCH_WIDTH; b++) begin
          rows[tail][b].valid   <= dispatch_en[b];
          rows[tail][b].done    <= 1'b0;
          rows[tail][b].arch_rd <= dispatch_arch_rd[b];
          rows[tail][b].phys_rd <= dispatch_phys_rd[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed testbench for rob_alloc_ctrl: dispatch, completion, wrap, flush and reset.
module tb_rob_alloc_ctrl;
  import rob_alloc_ctrl_pkg::*;

  localparam int WB = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [DISPATCH_WIDTH-1:0]                           en;
  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] arch;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] phys;
  logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]       rob_addr;
  logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]  bank_addr;
  logic                                                full;
  logic [WB-1:0]                                       cmpl_en;
  logic [WB-1:0][ROB_ADDR_WIDTH-1:0]                   cmpl_rob;
  logic [WB-1:0][DISPATCH_ADDR_WIDTH-1:0]              cmpl_bank;
  logic                                                flush;
  logic [DISPATCH_WIDTH-1:0]                           commit_en;
  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] commit_arch;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_phys;
  logic [ROB_ADDR_WIDTH-1:0]                           commit_rob;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_alloc_ctrl #(.WB_WIDTH(WB)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .dispatch_en        (en),
    .dispatch_arch_rd   (arch),
    .dispatch_phys_rd   (phys),
    .dispatch_rob_addr  (rob_addr),
    .dispatch_bank_addr (bank_addr),
    .dispatch_full      (full),
    .cmpl_en            (cmpl_en),
    .cmpl_rob_addr      (cmpl_rob),
    .cmpl_bank_addr     (cmpl_bank),
    .flush              (flush),
    .commit_en          (commit_en),
    .commit_arch_rd     (commit_arch),
    .commit_phys_rd     (commit_phys),
    .commit_rob_addr    (commit_rob)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en        = '0;
    arch      = '0;
    phys      = '0;
    cmpl_en   = '0;
    cmpl_rob  = '0;
    cmpl_bank = '0;
    flush     = 1'b0;
  endtask

  task automatic pulse_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic fill_rows(input int n);
    for (int i = 0; i < n; i++) begin
      en      = 2'b11;
      phys[0] = 6'(i);
      phys[1] = 6'(i + 32);
      tick();
    end
    idle();
  endtask

  task automatic complete_row0();
    cmpl_en      = 2'b11;
    cmpl_rob[0]  = 3'd0;
    cmpl_bank[0] = 1'b0;
    cmpl_rob[1]  = 3'd0;
    cmpl_bank[1] = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #2;
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
    checks++; if (commit_en !== 2'b00) begin errors++; $display("FAIL reset_commit_en got %b want 00", commit_en); end
    checks++; if (rob_addr[0] !== 3'd0 || rob_addr[1] !== 3'd0) begin errors++; $display("FAIL reset_rob_addr got %0d/%0d want 0/0", rob_addr[0], rob_addr[1]); end
    checks++; if (bank_addr[0] !== 1'b0 || bank_addr[1] !== 1'b1) begin errors++; $display("FAIL bank_addr got %0d/%0d want 0/1", bank_addr[0], bank_addr[1]); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_dispatch();
    for (int g = 0; g < 3; g++) begin
      en      = 2'b11;
      arch[0] = 5'(2 * g + 1);
      arch[1] = 5'(2 * g + 2);
      phys[0] = 6'(8 + 2 * g);
      phys[1] = 6'(9 + 2 * g);
      #1;
      checks++; if (rob_addr[0] !== 3'(g) || rob_addr[1] !== 3'(g)) begin errors++; $display("FAIL dispatch_rob_addr g%0d got %0d/%0d want %0d", g, rob_addr[0], rob_addr[1], g); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL dispatch_full g%0d got %0b want 0", g, full); end
      checks++; if (commit_en !== 2'b00) begin errors++; $display("FAIL dispatch_no_commit g%0d got %b want 00", g, commit_en); end
      tick();
    end
    idle();
  endtask

  task automatic test_completion();
    cmpl_en      = 2'b01;
    cmpl_rob[0]  = 3'd0;
    cmpl_bank[0] = 1'b1;
    tick();
    cmpl_en      = 2'b10;
    cmpl_rob[1]  = 3'd0;
    cmpl_bank[1] = 1'b0;
    cmpl_rob[0]  = 3'd0;
    cmpl_bank[0] = 1'b0;
    #1;
    checks++; if (commit_en !== 2'b00) begin errors++; $display("FAIL cmpl_no_early_commit got %b want 00", commit_en); end
    tick();
    idle();
    #1;
    checks++; if (commit_en !== 2'b11) begin errors++; $display("FAIL cmpl_commit_en got %b want 11", commit_en); end
    checks++; if (commit_rob !== 3'd0) begin errors++; $display("FAIL cmpl_commit_rob got %0d want 0", commit_rob); end
    checks++; if (commit_phys[0] !== 6'd8 || commit_phys[1] !== 6'd9) begin errors++; $display("FAIL cmpl_commit_phys got %0d/%0d want 8/9", commit_phys[0], commit_phys[1]); end
    checks++; if (commit_arch[0] !== 5'd1 || commit_arch[1] !== 5'd2) begin errors++; $display("FAIL cmpl_commit_arch got %0d/%0d want 1/2", commit_arch[0], commit_arch[1]); end
    tick();
    checks++; if (commit_rob !== 3'd1) begin errors++; $display("FAIL cmpl_head_advance got %0d want 1", commit_rob); end
    checks++; if (commit_en !== 2'b00) begin errors++; $display("FAIL cmpl_row1_not_ready got %b want 00", commit_en); end
  endtask

  task automatic test_full_wrap();
    pulse_flush();
    for (int i = 0; i < ROB_ROWS; i++) begin
      en      = 2'b11;
      phys[0] = 6'(i);
      #1;
      checks++; if (rob_addr[0] !== 3'(i)) begin errors++; $display("FAIL fill_rob_addr i%0d got %0d want %0d", i, rob_addr[0], i); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_early i%0d got %0b want 0", i, full); end
      tick();
    end
    idle();
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set got %0b want 1", full); end
    en = 2'b11;
    tick();
    idle();
    #1;
    checks++; if (dut.u_ptr.tail !== 3'd0) begin errors++; $display("FAIL full_ignore_tail got %0d want 0", dut.u_ptr.tail); end
    checks++; if (dut.u_ptr.count !== 4'd8) begin errors++; $display("FAIL full_ignore_count got %0d want 8", dut.u_ptr.count); end
    checks++; if (commit_phys[0] !== 6'd0) begin errors++; $display("FAIL full_ignore_row0 got %0d want 0", commit_phys[0]); end
    complete_row0();
    #1;
    checks++; if (commit_en !== 2'b11 || full !== 1'b1) begin errors++; $display("FAIL commit_while_full got en=%b full=%0b want 11/1", commit_en, full); end
    tick();
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_drop got %0b want 0", full); end
    en = 2'b11;
    #1;
    checks++; if (rob_addr[0] !== 3'd0) begin errors++; $display("FAIL wrap_rob_addr got %0d want 0", rob_addr[0]); end
    tick();
    idle();
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL refill_full got %0b want 1", full); end
  endtask

  task automatic test_partial_group();
    pulse_flush();
    en      = 2'b01;
    arch[0] = 5'd3;
    phys[0] = 6'd20;
    arch[1] = 5'd7;
    phys[1] = 6'd21;
    tick();
    idle();
    cmpl_en      = 2'b01;
    cmpl_rob[0]  = 3'd0;
    cmpl_bank[0] = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (commit_en !== 2'b00) begin errors++; $display("FAIL partial_invalid_cmpl got %b want 00", commit_en); end
    checks++; if (dut.rows[0][1].done !== 1'b0) begin errors++; $display("FAIL partial_done_set got %0b want 0", dut.rows[0][1].done); end
    cmpl_en      = 2'b01;
    cmpl_rob[0]  = 3'd0;
    cmpl_bank[0] = 1'b0;
    tick();
    idle();
    #1;
    checks++; if (commit_en !== 2'b01) begin errors++; $display("FAIL partial_commit_en got %b want 01", commit_en); end
    checks++; if (commit_phys[0] !== 6'd20 || commit_arch[0] !== 5'd3) begin errors++; $display("FAIL partial_fields got %0d/%0d want 20/3", commit_phys[0], commit_arch[0]); end
    tick();
    checks++; if (commit_en !== 2'b00 || dut.u_ptr.count !== 4'd0) begin errors++; $display("FAIL partial_empty got en=%b count=%0d want 00/0", commit_en, dut.u_ptr.count); end
  endtask

  task automatic test_simul();
    pulse_flush();
    fill_rows(ROB_ROWS - 1);
    complete_row0();
    en = 2'b11;
    #1;
    checks++; if (rob_addr[0] !== 3'd7 || commit_en !== 2'b11 || full !== 1'b0) begin errors++; $display("FAIL simul_pre got addr=%0d en=%b full=%0b want 7/11/0", rob_addr[0], commit_en, full); end
    tick();
    idle();
    #1;
    checks++; if (dut.u_ptr.count !== 4'd7) begin errors++; $display("FAIL simul_count got %0d want 7", dut.u_ptr.count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL simul_full got %0b want 0", full); end
    checks++; if (commit_rob !== 3'd1 || rob_addr[0] !== 3'd0) begin errors++; $display("FAIL simul_ptrs got head=%0d tail=%0d want 1/0", commit_rob, rob_addr[0]); end
  endtask

  task automatic test_flush();
    pulse_flush();
    fill_rows(5);
    complete_row0();
    flush        = 1'b1;
    en           = 2'b11;
    cmpl_en      = 2'b01;
    cmpl_rob[0]  = 3'd1;
    cmpl_bank[0] = 1'b0;
    #1;
    checks++; if (commit_en !== 2'b11) begin errors++; $display("FAIL flush_cycle_commit got %b want 11", commit_en); end
    tick();
    idle();
    #1;
    checks++; if (dut.u_ptr.count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", dut.u_ptr.count); end
    checks++; if (rob_addr[0] !== 3'd0 || commit_en !== 2'b00 || full !== 1'b0) begin errors++; $display("FAIL flush_outputs got addr=%0d en=%b full=%0b want 0/00/0", rob_addr[0], commit_en, full); end
    en = 2'b11;
    tick();
    idle();
    #1;
    checks++; if (commit_en !== 2'b00) begin errors++; $display("FAIL flush_stale_done got %b want 00", commit_en); end
  endtask

  task automatic test_reset_mid();
    pulse_flush();
    fill_rows(5);
    complete_row0();
    #1;
    checks++; if (commit_en !== 2'b11) begin errors++; $display("FAIL rstmid_pre got %b want 11", commit_en); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dut.u_ptr.count !== 4'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", dut.u_ptr.count); end
    checks++; if (rob_addr[0] !== 3'd0 || commit_en !== 2'b00 || full !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got addr=%0d en=%b full=%0b want 0/00/0", rob_addr[0], commit_en, full); end
    #2;
    rst_n = 1'b1;
    tick();
    checks++; if (commit_en !== 2'b00 || rob_addr[0] !== 3'd0) begin errors++; $display("FAIL rstmid_after got en=%b addr=%0d want 00/0", commit_en, rob_addr[0]); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_dispatch();
    test_completion();
    test_full_wrap();
    test_partial_group();
    test_simul();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_alloc_ctrl.md
# rob_alloc_ctrl

Allocation and retirement controller for the banked reorder buffer. It hands out one ROB row per dispatch group, with lane i landing in bank i, and records each entry's arch/phys destination and completion status. It retires the head row in order once every valid entry in it has completed. It sits between the dispatch stage (through the dispatch interface) and the commit/free-list logic, and is the single owner of the head/tail pointers and the `full` flag.

## Interface
Parameters (widths come from package `parameters`):
- `DISPATCH_WIDTH`, package, lanes per group = number of ROB banks.
- `ROB_ADDR_WIDTH`, package, row index width; `ROB_ROWS = 2**ROB_ADDR_WIDTH`.
- `WB_WIDTH`, 2, number of completion ports.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `dispatch`  robDispatchIf.in  -  `en`/`arch_rd`/`phys_rd` per lane in; `rob_addr`/`bank_addr`/`full` out.
- `cmpl_en`  in  [WB_WIDTH]  completion valid per port.
- `cmpl_rob_addr`  in  [WB_WIDTH] x ROB_ADDR_WIDTH  row of the completing entry.
- `cmpl_bank_addr`  in  [WB_WIDTH] x DISPATCH_ADDR_WIDTH  bank of the completing entry.
- `flush`  in  1  discard all entries.
- `commit_en`  out  [DISPATCH_WIDTH]  lane retires this cycle.
- `commit_arch_rd`  out  [DISPATCH_WIDTH] x 5  retiring arch destination.
- `commit_phys_rd`  out  [DISPATCH_WIDTH] x PHYS_REGS_ADDR_WIDTH  retiring phys destination.
- `commit_rob_addr`  out  ROB_ADDR_WIDTH  row being retired.

## Operation
- State per entry (row r, bank b): `valid`, `done`, `arch_rd`, `phys_rd`.
- Control state: `head` and `tail` (ROB_ADDR_WIDTH bits, wrap modulo ROB_ROWS) and `count` (ROB_ADDR_WIDTH+1 bits, 0..ROB_ROWS).

Dispatch:
- `rob_addr[i] = tail` for all i; `bank_addr[i] = i`. Both are combinational.
- `full = (count == ROB_ROWS)`. It depends only on registered state.
- Accept when `|en && !full`. At the edge, row `tail` gets, per lane: `valid = en[i]`, `done = 0`, and the rd fields written. Then `tail++` and `count++`.
- A group with all `en = 0` allocates nothing.
- Dispatch while `full` is ignored and leaves state unchanged. The bench flags it as a protocol error.

Completion:
- Each `cmpl_en[k]` sets `done[row][bank]` at the edge.
- A completion that targets an entry with `valid = 0` is ignored.
- Two ports hitting the same entry is harmless.

Commit:
- The head row is retirable when `count != 0` and, for every bank, `!valid || done`.
- When retirable, in the same cycle:
  - `commit_en[i] = valid[head][i]`;
  - the rd outputs show the head row's fields;
  - `commit_rob_addr = head`.
- At the edge, the row's `valid` bits clear, `head++` and `count--`.
- At most one row retires per cycle.
- When not retirable, `commit_en = 0` and the other commit outputs are don't-care (driven from the head row).

Simultaneous events:
- Dispatch and commit in the same cycle: `count` is unchanged and both pointers advance.
- Dispatch with `count == ROB_ROWS-1` plus commit: allowed.
- Commit while `full`: frees a row; `full` drops in the next cycle.

Flush:
- Highest priority. At the edge, all `valid`/`done` clear, `head = tail = 0`, `count = 0`.
- A dispatch or completion in the flush cycle is discarded.
- Commit outputs are still driven combinationally in the flush cycle. Consumers gate them with `flush`.

Reset (asynchronous, `rst_n` low):
- All `valid`/`done` = 0; `head = tail = count = 0`.
- Resulting outputs: `full = 0`, `commit_en = 0`, `rob_addr = 0`.
- A reset asserted mid-operation has the same effect as flush, applied immediately.

## Timing
- The dispatch address is valid in the same cycle as `en`. Entry state is written at the following edge.
- Completion at edge N makes the row retirable from cycle N+1. An entry dispatched at edge N can complete at the earliest in cycle N+1 and commit at the earliest in cycle N+2.
- Commit outputs are combinational from registered state. There is no input-to-commit combinational path.
- `full` is registered-state derived and updates one cycle after the count change.

## Structure
- `ROB_ROWS` and the struct `rob_entry_t {valid, done, arch_rd, phys_rd}` belong in package `parameters`.
- Natural sub-module: `rob_ptr_ctrl`. It holds head/tail/count, generates `full`, and takes the alloc/retire/flush pulses.
- The top level holds the entry array, the completion decode and the retirable check.

## Test plan
- Reset, then dispatch 3 groups with en = all ones, phys_rd 8/9/..: `rob_addr` = 0, 1, 2; `full = 0`; no commit.
- Complete bank1 of row 0, then bank0 one cycle later: `commit_en` = all ones for row 0 exactly one cycle after the last completion; the next cycle `head = 1`.
- Fill all ROB_ROWS rows: `full = 1` on the next cycle. A further dispatch is ignored (tail unchanged). Retire row 0 → `full = 0` on the next cycle; a dispatch then gets `rob_addr = 0` (wrap).
- Group with en = {1,0}: `commit_en` = {1,0} after completion of bank0 only. A completion to bank1 of that row is ignored.
- Same-cycle dispatch and commit at `count = ROB_ROWS-1`: `count` stays at ROB_ROWS-1 and `full` stays 0.
- Flush with 5 rows occupied and completions pending: next cycle `count = 0`, `rob_addr = 0`, `commit_en = 0`. Repeat with `rst_n` pulsed mid-cycle: same result, applied immediately.
